quad_tach_counter: RTL and testbench
====================================

// Module: quad_tach_counter
// PURPOSE
//  Parametrised per-channel quadrature tachometer front end for the BDC motor controller.
//  Synchronises and deglitches a 2-bit encoder input, decodes x4 quadrature into a signed position count,
//  detects illegal transitions, and measures velocity as net counts per fixed window.
//  One instance per motor channel; the SPI register file reads count/snapshot/velocity/status.
// PARAMETERS
//  WIDTH   16    position count width, two's complement, wraps modulo 2^WIDTH
//  FILT    3     consecutive equal synchronised samples required to accept a new tach state (>=1)
//  WINDOW  1000  velocity measurement window length in clk cycles (>=2)
//  VWIDTH  12    velocity result width, signed, saturating
// PORTS
//  clk       in   1       system clock, all logic on rising edge
//  resetn    in   1       asynchronous active-low reset
//  tach      in   2       raw encoder inputs {B,A}, asynchronous to clk
//  clear     in   1       synchronous: zero count, velocity accumulator, restart window
//  snap      in   1       one-cycle strobe: copy count into snapcount (coherent multi-byte read)
//  errclr    in   1       one-cycle strobe: clear sticky err
//  count     out  WIDTH   live signed position count
//  snapcount out  WIDTH   count captured at last snap
//  velocity  out  VWIDTH  net signed counts over the last completed window
//  vel_valid out  1       one-cycle pulse when velocity updates
//  dir       out  1       direction of last legal step: 1 = forward (increment), 0 = reverse
//  err       out  1       sticky: illegal (two-bit) transition seen
// BEHAVIOUR
//  Reset (resetn=0, async): all outputs 0; sync/filter regs, filtered state, accumulator, window counter to 0.
//   Filtered state resets to 2'b00 so a tach held at 00 through reset produces no step.
//  Sync: 2-flop synchroniser s1->s2 on tach. Filter: candidate tracks s2; stability counter restarts on any
//   change; filtered state takes candidate when s2 has been equal for FILT consecutive cycles.
//  Latency: stable tach change -> count/dir/err update = FILT+3 clk cycles.
//  Decode (old filtered state -> new): forward sequence 00->01->11->10->00 = +1; reverse of it = -1;
//   unchanged = 0; two-bit change (00<->11, 01<->10) = illegal: count unchanged, err<=1, dir unchanged.
//  count: WIDTH-bit add, wraps silently (max+1 -> min, 0-1 -> all ones). dir updates only on legal step.
//  Velocity: window counter 0..WINDOW-1; accumulator adds each legal step. On terminal cycle velocity <=
//   accumulator saturated to [-2^(VWIDTH-1), 2^(VWIDTH-1)-1], vel_valid=1 for that cycle, accumulator <=
//   the step of that same cycle (step on terminal cycle belongs to the new window). Accumulator itself
//   saturates at VWIDTH+1 bits so it cannot wrap.
//  clear: count<=0, accumulator<=0, window counter<=0, no vel_valid that cycle; a step in the same cycle is
//   discarded; velocity, snapcount, dir, err hold.
//  snap: snapcount <= count value before any same-cycle step (pre-update); snap+clear -> pre-clear value.
//  errclr: err<=0 unless an illegal transition is decoded the same cycle (set wins).
//  Glitches shorter than FILT cycles after sync are never seen by the decoder.
// TESTING
//  Reset: assert resetn=0 mid-count with tach=01 -> all outputs 0 immediately; release -> one +1 step
//   after FILT+3 cycles (filtered state starts at 00).
//  Forward/reverse: tach 00->01->11->01->00->10 each held 200 cycles -> count 1,2,1,0,0xFFFF; dir 1,1,0,0,0.
//  Filter: FILT=3, pulse tach 00->01 for 2 cycles then back -> count stays 0; hold 3 cycles -> count=1
//   exactly 6 cycles after edge.
//  Illegal: tach 00->11 (stable) -> err=1, count 0; errclr alone -> err=0; errclr with new 11->00 -> err=1.
//  Wrap/snap: preload via 65535 forward steps then one more -> count 0; snap on same cycle as step ->
//   snapcount=0xFFFF.
//  Velocity: WINDOW=1000, 40 forward steps in one window -> velocity=40, vel_valid 1-cycle pulse; 3000 steps
//   in window with VWIDTH=12 -> velocity=2047; reverse 10 -> -10; clear mid-window -> no pulse, restart.

Source files
------------

// File: rtl/quad_tach_counter.sv
// Quadrature tachometer front end for one motor channel: synchronise and deglitch the
// encoder, decode x4 quadrature into a wrapping position count, flag illegal jumps, measure velocity.

module quad_tach_counter #(
  parameter int WIDTH  = 16,
  parameter int FILT   = 3,
  parameter int WINDOW = 1000,
  parameter int VWIDTH = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        tach,
  input  logic              clear,
  input  logic              snap,
  input  logic              errclr,
  output logic [WIDTH-1:0]  count,
  output logic [WIDTH-1:0]  snapcount,
  output logic [VWIDTH-1:0] velocity,
  output logic              vel_valid,
  output logic              dir,
  output logic              err
);

  localparam int RW = $clog2(FILT + 1);
  localparam int WW = (WINDOW < 2) ? 1 : $clog2(WINDOW);
  localparam int AW = VWIDTH + 1;

  localparam logic [RW-1:0]        RUN_FULL = RW'(FILT);
  localparam logic [WW-1:0]        WIN_LAST = WW'(WINDOW - 1);
  localparam logic signed [AW:0]   ACC_MAX  = {2'b00, {(AW-1){1'b1}}};
  localparam logic signed [AW:0]   ACC_MIN  = {2'b11, {(AW-1){1'b0}}};
  localparam logic signed [AW-1:0] VEL_MAX  = {2'b00, {(VWIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] VEL_MIN  = {2'b11, {(VWIDTH-1){1'b0}}};

  logic [1:0]           s1, s2, cand, filt, filt_prev;
  logic [RW-1:0]        run, run_next;
  logic [WW-1:0]        win;
  logic signed [AW-1:0] acc, acc_sat, step_acc;
  logic signed [AW:0]   acc_sum, step_ext;
  logic [VWIDTH-1:0]    vel_sat;
  logic [1:0]           phase_old, phase_new, delta;
  logic                 step_fwd, step_rev, illegal;

  // Maps the Gray-coded encoder state onto a position index 0..3 along the forward sequence.
  function automatic logic [1:0] phase_of(input logic [1:0] t);
    return {t[1], t[1] ^ t[0]};
  endfunction

  always_comb begin
    run_next = RW'(1);
    if (s2 == cand) begin
      run_next = (run == RUN_FULL) ? run : run + 1'b1;
    end
  end

  always_comb begin
    phase_old = phase_of(filt_prev);
    phase_new = phase_of(filt);
    delta     = phase_new - phase_old;
    step_fwd  = (delta == 2'd1);
    step_rev  = (delta == 2'd3);
    illegal   = (delta == 2'd2);
  end

  // The accumulator is one bit wider than the result and clamps, so a fast window cannot wrap it.
  always_comb begin
    step_acc = '0;
    if (step_fwd) begin
      step_acc = {{(AW-1){1'b0}}, 1'b1};
    end else if (step_rev) begin
      step_acc = '1;
    end
    step_ext = {step_acc[AW-1], step_acc};
    acc_sum  = {acc[AW-1], acc} + step_ext;
    acc_sat  = acc_sum[AW-1:0];
    if (acc_sum > ACC_MAX) begin
      acc_sat = ACC_MAX[AW-1:0];
    end else if (acc_sum < ACC_MIN) begin
      acc_sat = ACC_MIN[AW-1:0];
    end
    vel_sat = acc[VWIDTH-1:0];
    if (acc > VEL_MAX) begin
      vel_sat = VEL_MAX[VWIDTH-1:0];
    end else if (acc < VEL_MIN) begin
      vel_sat = VEL_MIN[VWIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1        <= '0;
      s2        <= '0;
      cand      <= '0;
      run       <= '0;
      filt      <= '0;
      filt_prev <= '0;
    end else begin
      s1        <= tach;
      s2        <= s1;
      cand      <= s2;
      run       <= run_next;
      filt_prev <= filt;
      if (run_next == RUN_FULL) begin
        filt <= s2;
      end
    end
  end

  // Clear discards any step decoded in the same cycle; snap always sees the pre-update count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count     <= '0;
      snapcount <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
      dir       <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
      win       <= '0;
    end else begin
      vel_valid <= 1'b0;
      if (snap) begin
        snapcount <= count;
      end
      if (clear) begin
        count <= '0;
        acc   <= '0;
        win   <= '0;
      end else begin
        if (step_fwd) begin
          count <= count + 1'b1;
          dir   <= 1'b1;
        end else if (step_rev) begin
          count <= count - 1'b1;
          dir   <= 1'b0;
        end
        if (win == WIN_LAST) begin
          win       <= '0;
          velocity  <= vel_sat;
          vel_valid <= 1'b1;
          acc       <= step_acc;
        end else begin
          win <= win + 1'b1;
          acc <= acc_sat;
        end
      end
      if (illegal && !clear) begin
        err <= 1'b1;
      end else if (errclr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_tach_counter.sv
// Self-checking bench for quad_tach_counter: directed tables and sequences plus a randomized
// encoder walk compared against a step-level position model.

module tb_quad_tach_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [1:0]  tach_a, tach_b;
  logic        clear_a, snap_a, errclr_a, clear_b, snap_b, errclr_b;
  logic [15:0] count_a, snapcount_a;
  logic [11:0] velocity_a;
  logic        vel_valid_a, dir_a, err_a;
  logic [7:0]  count_b, snapcount_b;
  logic [11:0] velocity_b;
  logic        vel_valid_b, dir_b, err_b;

  quad_tach_counter #(.WIDTH(16), .FILT(3), .WINDOW(1000), .VWIDTH(12)) dut_a (
    .clk(clk), .resetn(resetn), .tach(tach_a), .clear(clear_a), .snap(snap_a),
    .errclr(errclr_a), .count(count_a), .snapcount(snapcount_a), .velocity(velocity_a),
    .vel_valid(vel_valid_a), .dir(dir_a), .err(err_a)
  );

  // Fast-filter, long-window instance for wrap and velocity saturation.
  quad_tach_counter #(.WIDTH(8), .FILT(1), .WINDOW(4000), .VWIDTH(12)) dut_b (
    .clk(clk), .resetn(resetn), .tach(tach_b), .clear(clear_b), .snap(snap_b),
    .errclr(errclr_b), .count(count_b), .snapcount(snapcount_b), .velocity(velocity_b),
    .vel_valid(vel_valid_b), .dir(dir_b), .err(err_b)
  );

  typedef struct {
    logic [1:0]  tach;
    int          hold;
    logic [15:0] exp_count;
    logic        exp_dir;
    logic        exp_err;
  } vec_t;

  vec_t       fr_tab[5];
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         vectors = 0;
  int         miscompares = 0;
  int         phase_a = 0;
  int         phase_b = 0;
  logic [15:0] m_count;
  logic        m_dir, m_err;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [1:0] t, input int hold);
    tach_a = t;
    tick(hold);
  endtask

  task automatic step_a(input int d);
    phase_a = (phase_a + d + 4) % 4;
    tach_a  = seq[phase_a];
  endtask

  task automatic step_b(input int d);
    phase_b = (phase_b + d + 4) % 4;
    tach_b  = seq[phase_b];
  endtask

  initial begin
    int pulse_k;
    int extra;

    fr_tab[0] = '{2'b01, 200, 16'h0001, 1'b1, 1'b0};
    fr_tab[1] = '{2'b11, 200, 16'h0002, 1'b1, 1'b0};
    fr_tab[2] = '{2'b01, 200, 16'h0001, 1'b0, 1'b0};
    fr_tab[3] = '{2'b00, 200, 16'h0000, 1'b0, 1'b0};
    fr_tab[4] = '{2'b10, 200, 16'hFFFF, 1'b0, 1'b0};

    resetn = 1'b0;
    tach_a = 2'b00; tach_b = 2'b00;
    clear_a = 0; snap_a = 0; errclr_a = 0;
    clear_b = 0; snap_b = 0; errclr_b = 0;
    tick(3);
    check_output("rst_count_a", count_a, 0);
    check_output("rst_snap_a", snapcount_a, 0);
    check_output("rst_vel_a", velocity_a, 0);
    check_output("rst_vv_a", vel_valid_a, 0);
    check_output("rst_dir_a", dir_a, 0);
    check_output("rst_err_a", err_a, 0);
    check_output("rst_count_b", count_b, 0);
    resetn = 1'b1;
    tick(20);
    check_output("idle_count", count_a, 0);

    // Short pulse is filtered out; a held change lands exactly FILT+3 cycles later.
    tach_a = 2'b01; tick(2); tach_a = 2'b00; tick(20);
    check_output("glitch_count", count_a, 0);
    tach_a = 2'b01; tick(5);
    check_output("lat_before", count_a, 0);
    tick(1);
    check_output("lat_at", count_a, 1);
    check_output("lat_dir", dir_a, 1);

    // Asynchronous reset with tach held at 01, then one step after release.
    #1 resetn = 1'b0;
    #1;
    check_output("async_rst_count", count_a, 0);
    check_output("async_rst_dir", dir_a, 0);
    tick(2);
    resetn = 1'b1;
    tick(5);
    check_output("post_rst_before", count_a, 0);
    tick(1);
    check_output("post_rst_step", count_a, 1);
    apply_stimulus(2'b00, 20);
    check_output("back_zero", count_a, 0);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(fr_tab[i].tach, fr_tab[i].hold);
      check_output($sformatf("fr_count_%0d", i), count_a, fr_tab[i].exp_count);
      check_output($sformatf("fr_dir_%0d", i), dir_a, fr_tab[i].exp_dir);
      check_output($sformatf("fr_err_%0d", i), err_a, fr_tab[i].exp_err);
    end

    // Illegal transitions and sticky error handling.
    apply_stimulus(2'b00, 20);
    check_output("wrap_up_count", count_a, 0);
    apply_stimulus(2'b11, 20);
    check_output("illegal_err", err_a, 1);
    check_output("illegal_count", count_a, 0);
    check_output("illegal_dir", dir_a, 1);
    errclr_a = 1; tick(1); errclr_a = 0;
    check_output("errclr_alone", err_a, 0);
    tick(3);
    tach_a = 2'b00; tick(5);
    errclr_a = 1; tick(1); errclr_a = 0;
    check_output("err_set_wins", err_a, 1);
    check_output("illegal2_count", count_a, 0);
    tick(10);
    errclr_a = 1; tick(1); errclr_a = 0;
    check_output("errclr_again", err_a, 0);
    phase_a = 0;

    // Wrap max -> 0 on the 8-bit instance with snap coinciding with the wrapping step.
    clear_b = 1; tick(1); clear_b = 0;
    check_output("b_clear", count_b, 0);
    for (int i = 0; i < 255; i++) begin
      step_b(1); tick(1);
    end
    tick(10);
    check_output("b_max", count_b, 8'hFF);
    check_output("b_dir", dir_b, 1);
    step_b(1); tick(3);
    snap_b = 1; tick(1); snap_b = 0;
    check_output("b_wrap", count_b, 0);
    check_output("b_snap_pre", snapcount_b, 8'hFF);
    tick(10);

    // 40 forward steps in one aligned window.
    clear_a = 1; tick(1); clear_a = 0;
    check_output("clear_count", count_a, 0);
    pulse_k = 0;
    for (int k = 1; k <= 1100 && pulse_k == 0; k++) begin
      if ((k % 10) == 1 && k < 400) step_a(1);
      tick(1);
      if (vel_valid_a) pulse_k = k;
    end
    check_output("vel40_when", pulse_k, 1000);
    check_output("vel40_value", velocity_a, 40);
    tick(1);
    check_output("vel40_pulse_len", vel_valid_a, 0);
    check_output("vel40_count", count_a, 40);

    // Mid-window snap+clear: no pulse at the old boundary, new window starts at the clear.
    extra = 0;
    for (int k = 1; k <= 300; k++) begin
      if ((k % 10) == 1 && k < 50) step_a(1);
      tick(1);
      if (vel_valid_a) extra++;
    end
    snap_a = 1; clear_a = 1; tick(1); snap_a = 0; clear_a = 0;
    check_output("early_pulses", extra, 0);
    check_output("snap_clear", snapcount_a, 45);
    check_output("clear_count2", count_a, 0);
    check_output("vel_hold", velocity_a, 40);
    pulse_k = 0;
    for (int k = 1; k <= 1100 && pulse_k == 0; k++) begin
      if ((k % 10) == 1 && k < 100) step_a(-1);
      tick(1);
      if (vel_valid_a) pulse_k = k;
    end
    check_output("velrev_when", pulse_k, 1000);
    check_output("velrev_value", velocity_a, 12'hFF6);
    check_output("velrev_count", count_a, 16'hFFF6);
    check_output("velrev_dir", dir_a, 0);

    // 3000 steps in one window saturate the 12-bit velocity.
    clear_b = 1; tick(1); clear_b = 0;
    pulse_k = 0;
    for (int k = 1; k <= 4100 && pulse_k == 0; k++) begin
      if (k <= 3000) step_b(1);
      tick(1);
      if (vel_valid_b) pulse_k = k;
    end
    check_output("velsat_when", pulse_k, 4000);
    check_output("velsat_value", velocity_b, 12'd2047);
    check_output("velsat_count", count_b, 8'hB8);

    // Randomized walk against a step-level model of position, direction and error.
    m_count = 16'hFFF6; m_dir = 1'b0; m_err = 1'b0;
    for (int n = 0; n < 150; n++) begin
      int r, hold;
      r    = $urandom_range(0, 9);
      hold = $urandom_range(8, 16);
      if (r == 0) begin
        step_a(2); m_err = 1'b1;
      end else if (r <= 4) begin
        step_a(1); m_count = m_count + 16'd1; m_dir = 1'b1;
      end else if (r <= 8) begin
        step_a(-1); m_count = m_count - 16'd1; m_dir = 1'b0;
      end else begin
        tach_a = seq[(phase_a + 1) % 4];
        tick($urandom_range(1, 2));
        tach_a = seq[phase_a];
      end
      tick(hold);
      if ($urandom_range(0, 3) == 0) begin
        errclr_a = 1; tick(1); errclr_a = 0; m_err = 1'b0;
      end
      check_output($sformatf("rnd_count_%0d", n), count_a, m_count);
      check_output($sformatf("rnd_dir_%0d", n), dir_a, m_dir);
      check_output($sformatf("rnd_err_%0d", n), err_a, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
